// File: rtl/cpu_pkg.sv
// cpu_pkg
// Shared definitions for the 16-bit CPU control path: opcode constants,
// sequencer state encoding, ALU operation encodings, instruction field
// widths and the register index that mirrors the program counter.
package cpu_pkg;

  localparam int DATA_W   = 16;
  localparam int OPCODE_W = 4;
  localparam int REG_W    = 4;
  localparam int IMM_W    = 8;

  localparam logic [OPCODE_W-1:0] OP_NOP  = 4'h0;
  localparam logic [OPCODE_W-1:0] OP_ADD  = 4'h1;
  localparam logic [OPCODE_W-1:0] OP_SUB  = 4'h2;
  localparam logic [OPCODE_W-1:0] OP_AND  = 4'h3;
  localparam logic [OPCODE_W-1:0] OP_OR   = 4'h4;
  localparam logic [OPCODE_W-1:0] OP_LDI  = 4'h5;
  localparam logic [OPCODE_W-1:0] OP_BEQZ = 4'h6;
  localparam logic [OPCODE_W-1:0] OP_HALT = 4'hF;

  // Register 15 reads back the PC and must never be written.
  localparam logic [REG_W-1:0] PC_REG = 4'd15;

  typedef enum logic [2:0] {
    FETCH,
    DECODE,
    EXECUTE,
    WRITEBACK,
    HALTED
  } state_e;

  typedef enum logic [1:0] {
    ALU_ADD = 2'd0,
    ALU_SUB = 2'd1,
    ALU_AND = 2'd2,
    ALU_OR  = 2'd3
  } alu_op_e;

  function automatic logic [DATA_W-1:0] sext_imm8(input logic [IMM_W-1:0] imm);
    return {{(DATA_W-IMM_W){imm[IMM_W-1]}}, imm};
  endfunction

endpackage

// File: rtl/instr_decode.sv
// instr_decode
// Purely combinational decoder from the instruction register to register
// fields, the sign-extended immediate and instruction class flags.
// Ports:
//   ir         in  16  instruction register
//   rd/rs0/rs1 out  4  register fields
//   sext_imm   out 16  sign-extended imm8
//   is_*       out  1  instruction class flags
//   writes_rd  out  1  instruction produces a register result
module instr_decode
  import cpu_pkg::*;
(
  input  logic [DATA_W-1:0] ir,
  output logic [REG_W-1:0]  rd,
  output logic [REG_W-1:0]  rs0,
  output logic [REG_W-1:0]  rs1,
  output logic [DATA_W-1:0] sext_imm,
  output logic              is_alu,
  output logic              is_ldi,
  output logic              is_beqz,
  output logic              is_halt,
  output logic              is_illegal,
  output logic              writes_rd
);

  logic [OPCODE_W-1:0] opcode;
  logic                is_nop;
  logic                bad_opcode;

  assign opcode   = ir[15:12];
  assign rd       = ir[11:8];
  assign rs0      = ir[7:4];
  assign rs1      = ir[3:0];
  assign sext_imm = sext_imm8(ir[IMM_W-1:0]);

  assign is_nop  = (opcode == OP_NOP);
  assign is_alu  = (opcode >= OP_ADD) && (opcode <= OP_OR);
  assign is_ldi  = (opcode == OP_LDI);
  assign is_beqz = (opcode == OP_BEQZ);
  assign is_halt = (opcode == OP_HALT);

  assign writes_rd  = is_alu | is_ldi;
  assign bad_opcode = ~(is_nop | is_alu | is_ldi | is_beqz | is_halt);

  // A write aimed at the PC mirror is rejected like an unknown opcode.
  assign is_illegal = bad_opcode | (writes_rd & (rd == PC_REG));

endmodule

// File: rtl/instr_sequencer.sv
// instr_sequencer
// Multi-cycle fetch/decode/execute/writeback controller. Owns the PC, the
// instruction register and the result register, drives the RegFile read
// selects and write port, and steers the external ALU.
// Ports:
//   clk, rst_n                    clock, async active-low reset
//   imem_req/addr/ready/rdata     instruction fetch handshake
//   sel0, sel1, insr              RegFile read selects
//   rf_outvalue                   RegFile contents of register insr
//   alu_op, alu_result            external ALU control and result
//   write_address/data_in/write_en RegFile write port
//   pc                            program counter
//   halted                        sticky halt indication
//   illegal                       one-cycle pulse on an illegal instruction
module instr_sequencer
  import cpu_pkg::*;
#(
  parameter logic [DATA_W-1:0] RESET_PC = 16'h0000
) (
  input  logic              clk,
  input  logic              rst_n,
  output logic              imem_req,
  output logic [DATA_W-1:0] imem_addr,
  input  logic              imem_ready,
  input  logic [DATA_W-1:0] imem_rdata,
  output logic [REG_W-1:0]  sel0,
  output logic [REG_W-1:0]  sel1,
  output logic [REG_W-1:0]  insr,
  input  logic [DATA_W-1:0] rf_outvalue,
  output logic [1:0]        alu_op,
  input  logic [DATA_W-1:0] alu_result,
  output logic [REG_W-1:0]  write_address,
  output logic [DATA_W-1:0] data_in,
  output logic              write_en,
  output logic [DATA_W-1:0] pc,
  output logic              halted,
  output logic              illegal
);

  state_e            state_q, state_d;
  logic [DATA_W-1:0] pc_q, pc_d;
  logic [DATA_W-1:0] ir_q, ir_d;
  logic [DATA_W-1:0] res_q, res_d;

  logic [REG_W-1:0]    rd, rs0, rs1;
  logic [DATA_W-1:0]   sext_imm;
  logic                is_alu, is_ldi, is_beqz, is_halt, is_illegal, writes_rd;
  logic [OPCODE_W-1:0] alu_code;

  instr_decode u_decode (
    .ir         (ir_q),
    .rd         (rd),
    .rs0        (rs0),
    .rs1        (rs1),
    .sext_imm   (sext_imm),
    .is_alu     (is_alu),
    .is_ldi     (is_ldi),
    .is_beqz    (is_beqz),
    .is_halt    (is_halt),
    .is_illegal (is_illegal),
    .writes_rd  (writes_rd)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= FETCH;
      pc_q    <= RESET_PC;
      ir_q    <= '0;
      res_q   <= '0;
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
      ir_q    <= ir_d;
      res_q   <= res_d;
    end
  end

  always_comb begin
    state_d = state_q;
    pc_d    = pc_q;
    ir_d    = ir_q;
    res_d   = res_q;
    unique case (state_q)
      FETCH: begin
        if (imem_ready) begin
          ir_d    = imem_rdata;
          pc_d    = pc_q + 16'd1;
          state_d = DECODE;
        end
      end
      DECODE: begin
        if (is_halt) begin
          state_d = HALTED;
        end else if (is_illegal) begin
          state_d = FETCH;
        end else if (is_alu || is_ldi || is_beqz) begin
          state_d = EXECUTE;
        end else begin
          state_d = FETCH;
        end
      end
      EXECUTE: begin
        if (is_alu) begin
          res_d = alu_result;
        end else if (is_ldi) begin
          res_d = sext_imm;
        end
        if (is_beqz) begin
          // pc_q already points past the branch, so the offset is relative to pc+1.
          if (rf_outvalue == '0) begin
            pc_d = pc_q + sext_imm;
          end
          state_d = FETCH;
        end else begin
          state_d = WRITEBACK;
        end
      end
      WRITEBACK: state_d = FETCH;
      HALTED:    state_d = HALTED;
      default:   state_d = FETCH;
    endcase
  end

  // Selects come straight from IR, which only changes when a fetch completes,
  // so they hold through EXECUTE/WRITEBACK and move only into the next DECODE.
  assign sel0     = rs0;
  assign sel1     = rs1;
  assign insr     = rd;
  assign alu_code = ir_q[15:12] - 4'd1;
  assign alu_op   = is_alu ? alu_code[1:0] : ALU_ADD;

  // Reset qualification keeps the request low while rst_n is held.
  assign imem_req      = (state_q == FETCH) && rst_n;
  assign imem_addr     = pc_q;
  assign pc            = pc_q;
  assign write_address = rd;
  assign data_in       = res_q;
  assign write_en      = (state_q == WRITEBACK) && writes_rd && !is_illegal;
  assign halted        = (state_q == HALTED);
  assign illegal       = (state_q == DECODE) && is_illegal;

endmodule

// File: tb/tb_instr_sequencer.sv
// tb_instr_sequencer
// Drives instr_sequencer with a small instruction memory, a RegFile model and
// a model ALU. Expected RegFile writes are queued when a program is loaded and
// popped whenever the sequencer asserts write_en.
module tb_instr_sequencer;

  logic        clk;
  logic        rst_n;
  logic        imem_req;
  logic [15:0] imem_addr;
  logic        imem_ready;
  logic [15:0] imem_rdata;
  logic [3:0]  sel0, sel1, insr;
  logic [15:0] rf_outvalue;
  logic [1:0]  alu_op;
  logic [15:0] alu_result;
  logic [3:0]  write_address;
  logic [15:0] data_in;
  logic        write_en;
  logic [15:0] pc;
  logic        halted;
  logic        illegal;

  typedef struct {
    logic [3:0]  addr;
    logic [15:0] data;
  } wr_t;

  wr_t         expQ[$];
  wr_t         monWr;
  logic [15:0] mem [64];
  logic [15:0] regs [16];
  logic [15:0] out0, out1;
  int          passCount;
  int          failCount;
  int          totalCount;
  int          illegalCount;

  instr_sequencer #(.RESET_PC(16'h0000)) dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .imem_req      (imem_req),
    .imem_addr     (imem_addr),
    .imem_ready    (imem_ready),
    .imem_rdata    (imem_rdata),
    .sel0          (sel0),
    .sel1          (sel1),
    .insr          (insr),
    .rf_outvalue   (rf_outvalue),
    .alu_op        (alu_op),
    .alu_result    (alu_result),
    .write_address (write_address),
    .data_in       (data_in),
    .write_en      (write_en),
    .pc            (pc),
    .halted        (halted),
    .illegal       (illegal)
  );

  // Free-running clock, rising edges at 5, 15, 25, ...
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Instruction memory answers combinationally from the fetch address.
  assign imem_rdata = mem[imem_addr[5:0]];

  // RegFile model: register 15 mirrors the PC, writes land on the rising edge.
  assign out0        = (sel0 == 4'd15) ? pc : regs[sel0];
  assign out1        = (sel1 == 4'd15) ? pc : regs[sel1];
  assign rf_outvalue = (insr == 4'd15) ? pc : regs[insr];

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < 16; i++) regs[i] <= 16'h0000;
    end else if (write_en && write_address != 4'd15) begin
      regs[write_address] <= data_in;
    end
  end

  // Model ALU.
  always_comb begin
    alu_result = 16'h0000;
    case (alu_op)
      2'd0: alu_result = out0 + out1;
      2'd1: alu_result = out0 - out1;
      2'd2: alu_result = out0 & out1;
      2'd3: alu_result = out0 | out1;
      default: alu_result = 16'h0000;
    endcase
  end

  task automatic checkOutput(input string tag, input logic [15:0] observed, input logic [15:0] expected);
    totalCount = totalCount + 1;
    assert (observed === expected) passCount = passCount + 1;
    else begin
      failCount = failCount + 1;
      $error("[TB] FAIL %s observed=%h expected=%h", tag, observed, expected);
    end
  endtask

  // Scoreboard side: every write the sequencer issues must match the oldest queued one.
  always @(negedge clk) begin
    if (rst_n && write_en) begin
      if (expQ.size() == 0) begin
        checkOutput("write_en_unexpected", {15'd0, write_en}, 16'h0000);
      end else begin
        monWr = expQ.pop_front();
        checkOutput("wb_addr", {12'd0, write_address}, {12'd0, monWr.addr});
        checkOutput("wb_data", data_in, monWr.data);
      end
    end
    if (rst_n && illegal) illegalCount = illegalCount + 1;
  end

  task automatic clearMem();
    for (int i = 0; i < 64; i++) mem[i] = 16'h0000;
  endtask

  task automatic pushWrite(input logic [3:0] addr, input logic [15:0] data);
    wr_t w;
    w.addr = addr;
    w.data = data;
    expQ.push_back(w);
  endtask

  // Holds reset for two cycles; returns at a falling edge with rst_n still low.
  task automatic applyStimulus(input logic ready);
    rst_n      = 1'b0;
    imem_ready = ready;
    repeat (2) @(negedge clk);
  endtask

  // Releases reset at a falling edge; returns inside the first FETCH cycle.
  task automatic releaseReset();
    rst_n = 1'b1;
    #1;
  endtask

  task automatic waitHalted(input int maxCycles);
    int n;
    n = 0;
    while (!halted && n < maxCycles) begin
      @(negedge clk);
      n++;
    end
    checkOutput("halted_reached", {15'd0, halted}, 16'h0001);
  endtask

  initial begin
    #100000;
    $display("[TB] FAIL watchdog expired");
    $fatal(1, "[TB] watchdog");
  end

  initial begin
    passCount    = 0;
    failCount    = 0;
    totalCount   = 0;
    illegalCount = 0;
    rst_n        = 1'b0;
    imem_ready   = 1'b1;
    clearMem();

    // LDI R1,7 from reset, then a reset pulled during WRITEBACK.
    $display("[TB] reset and first LDI");
    mem[0] = 16'h5107;
    mem[1] = 16'hF000;
    pushWrite(4'd1, 16'd7);
    applyStimulus(1'b1);
    checkOutput("rst_imem_req", {15'd0, imem_req}, 16'h0000);
    checkOutput("rst_pc", pc, 16'h0000);
    checkOutput("rst_write_en", {15'd0, write_en}, 16'h0000);
    checkOutput("rst_halted", {15'd0, halted}, 16'h0000);
    checkOutput("rst_illegal", {15'd0, illegal}, 16'h0000);
    checkOutput("rst_sels", {4'd0, sel0, sel1, insr}, 16'h0000);
    checkOutput("rst_alu_op", {14'd0, alu_op}, 16'h0000);
    checkOutput("rst_wr_port", {write_address, data_in[11:0]}, 16'h0000);
    releaseReset();
    checkOutput("c1_imem_req", {15'd0, imem_req}, 16'h0001);
    checkOutput("c1_imem_addr", imem_addr, 16'h0000);
    @(negedge clk);
    checkOutput("c2_pc", pc, 16'h0001);
    checkOutput("c2_insr", {12'd0, insr}, 16'h0001);
    @(negedge clk);
    checkOutput("c3_write_en", {15'd0, write_en}, 16'h0000);
    @(negedge clk);
    checkOutput("c4_write_en", {15'd0, write_en}, 16'h0001);
    checkOutput("c4_write_address", {12'd0, write_address}, 16'h0001);
    checkOutput("c4_data_in", data_in, 16'h0007);
    #1 rst_n = 1'b0;
    #1;
    checkOutput("wb_reset_write_en", {15'd0, write_en}, 16'h0000);
    checkOutput("wb_reset_data_in", data_in, 16'h0000);
    checkOutput("wb_reset_pc", pc, 16'h0000);
    checkOutput("sb_empty_t1", expQ.size(), 16'h0000);

    // LDI R2,5; LDI R3,3; SUB R4,R2,R3; HALT.
    $display("[TB] ALU program and halt");
    clearMem();
    mem[0] = 16'h5205;
    mem[1] = 16'h5303;
    mem[2] = 16'h2423;
    mem[3] = 16'hF000;
    pushWrite(4'd2, 16'd5);
    pushWrite(4'd3, 16'd3);
    pushWrite(4'd4, 16'd2);
    applyStimulus(1'b1);
    releaseReset();
    repeat (10) @(negedge clk);
    checkOutput("sub_exec_alu_op", {14'd0, alu_op}, 16'h0001);
    checkOutput("sub_exec_sels", {8'd0, sel0, sel1}, 16'h0023);
    @(negedge clk);
    checkOutput("sub_wb_write_en", {15'd0, write_en}, 16'h0001);
    checkOutput("sub_wb_addr", {12'd0, write_address}, 16'h0004);
    checkOutput("sub_wb_data", data_in, 16'h0002);
    waitHalted(20);
    repeat (5) @(negedge clk);
    checkOutput("halt_imem_req", {15'd0, imem_req}, 16'h0000);
    checkOutput("halt_sticky", {15'd0, halted}, 16'h0001);
    checkOutput("halt_pc", pc, 16'h0004);
    checkOutput("sb_empty_t2", expQ.size(), 16'h0000);
    mem[0] = 16'hF000;
    rst_n = 1'b0;
    @(negedge clk);
    checkOutput("halt_rst_halted", {15'd0, halted}, 16'h0000);
    releaseReset();
    checkOutput("halt_resume_req", {15'd0, imem_req}, 16'h0001);
    checkOutput("halt_resume_addr", imem_addr, 16'h0000);
    waitHalted(10);

    // BEQZ R0,-2 at address 10 branches back to 9.
    $display("[TB] BEQZ taken backwards");
    clearMem();
    mem[10] = 16'h60FE;
    applyStimulus(1'b1);
    releaseReset();
    repeat (20) @(negedge clk);
    checkOutput("beqz_fetch_addr", imem_addr, 16'h000A);
    @(negedge clk);
    checkOutput("beqz_decode_pc", pc, 16'h000B);
    @(negedge clk);
    checkOutput("beqz_exec_req", {15'd0, imem_req}, 16'h0000);
    @(negedge clk);
    checkOutput("beqz_next_req", {15'd0, imem_req}, 16'h0001);
    checkOutput("beqz_next_addr", imem_addr, 16'h0009);

    // imem_ready low for five cycles; the word changes before ready rises.
    $display("[TB] fetch stall");
    clearMem();
    mem[0] = 16'h5203;
    mem[1] = 16'hF000;
    pushWrite(4'd1, 16'd7);
    applyStimulus(1'b0);
    releaseReset();
    checkOutput("stall_c1_req", {15'd0, imem_req}, 16'h0001);
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      checkOutput("stall_req", {15'd0, imem_req}, 16'h0001);
      checkOutput("stall_pc", pc, 16'h0000);
      checkOutput("stall_insr", {12'd0, insr}, 16'h0000);
    end
    mem[0]     = 16'h5107;
    imem_ready = 1'b1;
    @(negedge clk);
    checkOutput("stall_done_pc", pc, 16'h0001);
    checkOutput("stall_done_insr", {12'd0, insr}, 16'h0001);
    waitHalted(20);
    checkOutput("sb_empty_t4", expQ.size(), 16'h0000);

    // Illegal opcode and a write to R15.
    $display("[TB] illegal instructions");
    clearMem();
    mem[0] = 16'h7000;
    mem[1] = 16'h5F01;
    mem[2] = 16'hF000;
    applyStimulus(1'b1);
    illegalCount = 0;
    releaseReset();
    @(negedge clk);
    checkOutput("illegal_op7", {15'd0, illegal}, 16'h0001);
    @(negedge clk);
    checkOutput("illegal_gap", {15'd0, illegal}, 16'h0000);
    @(negedge clk);
    checkOutput("illegal_r15", {15'd0, illegal}, 16'h0001);
    waitHalted(20);
    checkOutput("illegal_count", illegalCount[15:0], 16'h0002);
    checkOutput("illegal_pc", pc, 16'h0003);
    checkOutput("sb_empty_t5", expQ.size(), 16'h0000);

    $display("%0d/%0d checks passed", passCount, totalCount);
    $finish;
  end

endmodule
